// File: rtl/scan_decoder.sv
// scan_decoder: registered SEL_W-to-2^SEL_W one-hot decoder with enable.
// DIRECT mode decodes the input index. SCAN mode walks the active line
// across all outputs and advances one line every DIV clocks.
// Build option: define DECODER_ACTIVE_LOW_EN to drive d inverted
// (inactive/reset value all ones, e.g. common-anode digit select).
// idx and wrap keep the same polarity in both builds.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | disabled or in reset; d inactive, idx holds last value
//   ST_DIRECT | d decodes in, one clock of latency
//   ST_SCAN   | d walks idx upward, stepping when div_cnt hits DIV-1
module scan_decoder #(
  parameter int SEL_W = 2,
  parameter int DIV   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        in,
  output logic [(1<<SEL_W)-1:0]   d,
  output logic [SEL_W-1:0]        idx,
  output logic                    wrap
);

  localparam int N     = 1 << SEL_W;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [N-1:0]     ONE      = N'(1);

`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic [N-1:0] D_OFF = '1;
`else
  localparam logic [N-1:0] D_OFF = '0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
  logic              wrap_q, wrap_d;
  logic [N-1:0]      d_q, d_d;
  logic [N-1:0]      hot_d;

  // Next-state, next-index and scan timing; d is decoded from the next idx
  // so that d and idx always update in the same cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    div_cnt_d = '0;
    wrap_d    = 1'b0;
    hot_d     = '0;

    if (!en) begin
      state_d = ST_IDLE;
    end else if (!mode) begin
      state_d = ST_DIRECT;
      idx_d   = in;
    end else if (state_q != ST_SCAN) begin
      // Entering SCAN: start at in, first step lands DIV clocks later.
      state_d = ST_SCAN;
      idx_d   = in;
    end else begin
      state_d = ST_SCAN;
      if (div_cnt_q == CNT_LAST) begin
        idx_d  = idx_q + SEL_W'(1);
        wrap_d = &idx_q;
      end else begin
        div_cnt_d = div_cnt_q + CNT_W'(1);
      end
    end

    if (state_d != ST_IDLE) begin
      hot_d = ONE << idx_d;
    end
    d_d = hot_d ^ D_OFF;
  end

  // State and registered outputs; reset dominates all other inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      div_cnt_q <= '0;
      wrap_q    <= 1'b0;
      d_q       <= D_OFF;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      div_cnt_q <= div_cnt_d;
      wrap_q    <= wrap_d;
      d_q       <= d_d;
    end
  end

  assign d    = d_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Testbench for scan_decoder: two instances (SEL_W=2/DIV=4 and SEL_W=3/DIV=1).
// Stimulus pushes hand-computed expectations into per-instance queues; a
// monitor per instance pops one entry per clock and compares.
module tb_scan_decoder;

`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic AL = 1'b1;
`else
  localparam logic AL = 1'b0;
`endif

  typedef struct {
    logic [7:0] d;
    logic [2:0] idx;
    logic       w;
    int         n;
  } exp_t;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // instance A: SEL_W=2, DIV=4
  logic       rst_a, en_a, mode_a;
  logic [1:0] in_a;
  logic [3:0] d_a;
  logic [1:0] idx_a;
  logic       wrap_a;

  // instance B: SEL_W=3, DIV=1
  logic       rst_b, en_b, mode_b;
  logic [2:0] in_b;
  logic [7:0] d_b;
  logic [2:0] idx_b;
  logic       wrap_b;

  scan_decoder #(.SEL_W(2), .DIV(4)) u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .mode(mode_a), .in(in_a),
    .d(d_a), .idx(idx_a), .wrap(wrap_a)
  );

  scan_decoder #(.SEL_W(3), .DIV(1)) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .in(in_b),
    .d(d_b), .idx(idx_b), .wrap(wrap_b)
  );

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   na = 0;
  int   nb = 0;

  // ed is the active-high expected select; polarity applied here
  task automatic step_a(input logic r, input logic e, input logic m,
                        input logic [1:0] i, input logic [3:0] ed,
                        input logic [1:0] ei, input logic ew);
    exp_t x;
    @(negedge clk);
    rst_a = r; en_a = e; mode_a = m; in_a = i;
    x.d   = {4'b0, ed ^ {4{AL}}};
    x.idx = {1'b0, ei};
    x.w   = ew;
    x.n   = na;
    na++;
    qa.push_back(x);
  endtask

  task automatic step_b(input logic r, input logic e, input logic m,
                        input logic [2:0] i, input logic [7:0] ed,
                        input logic [2:0] ei, input logic ew);
    exp_t x;
    @(negedge clk);
    rst_b = r; en_b = e; mode_b = m; in_b = i;
    x.d   = ed ^ {8{AL}};
    x.idx = ei;
    x.w   = ew;
    x.n   = nb;
    nb++;
    qb.push_back(x);
  endtask

  // monitor A
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (qa.size() > 0) begin
      x = qa.pop_front();
      n_cmp++;
      if (d_a !== x.d[3:0] || idx_a !== x.idx[1:0] || wrap_a !== x.w) begin
        n_bad++;
        $display("FAIL A#%0d: got d=%b idx=%0d wrap=%b, expected d=%b idx=%0d wrap=%b",
                 x.n, d_a, idx_a, wrap_a, x.d[3:0], x.idx[1:0], x.w);
      end
    end
  end

  // monitor B
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (qb.size() > 0) begin
      x = qb.pop_front();
      n_cmp++;
      if (d_b !== x.d || idx_b !== x.idx || wrap_b !== x.w) begin
        n_bad++;
        $display("FAIL B#%0d: got d=%b idx=%0d wrap=%b, expected d=%b idx=%0d wrap=%b",
                 x.n, d_b, idx_b, wrap_b, x.d, x.idx, x.w);
      end
    end
  end

  initial begin
    rst_a = 1'b1; en_a = 1'b0; mode_a = 1'b0; in_a = 2'd0;
    rst_b = 1'b1; en_b = 1'b0; mode_b = 1'b0; in_b = 3'd0;

    fork
      begin : stim_a
        // reset, two clocks
        step_a(1, 0, 0, 2'd0, 4'b0000, 2'd0, 0);
        step_a(1, 0, 0, 2'd0, 4'b0000, 2'd0, 0);
        // DIRECT decode of every index
        step_a(0, 1, 0, 2'd0, 4'b0001, 2'd0, 0);
        step_a(0, 1, 0, 2'd1, 4'b0010, 2'd1, 0);
        step_a(0, 1, 0, 2'd2, 4'b0100, 2'd2, 0);
        step_a(0, 1, 0, 2'd3, 4'b1000, 2'd3, 0);
        // disable: d inactive, idx holds
        step_a(0, 0, 0, 2'd3, 4'b0000, 2'd3, 0);
        // SCAN from 2: 4 clks each, wrap on 3->0
        step_a(0, 1, 1, 2'd2, 4'b0100, 2'd2, 0);
        repeat (3) step_a(0, 1, 1, 2'd0, 4'b0100, 2'd2, 0);
        repeat (4) step_a(0, 1, 1, 2'd0, 4'b1000, 2'd3, 0);
        step_a(0, 1, 1, 2'd0, 4'b0001, 2'd0, 1);
        repeat (3) step_a(0, 1, 1, 2'd0, 4'b0001, 2'd0, 0);
        step_a(0, 1, 1, 2'd0, 4'b0010, 2'd1, 0);
        // en=0 dominates mode=1, then re-enable reloads from in
        step_a(0, 0, 1, 2'd0, 4'b0000, 2'd1, 0);
        step_a(0, 1, 1, 2'd3, 4'b1000, 2'd3, 0);
        repeat (3) step_a(0, 1, 1, 2'd1, 4'b1000, 2'd3, 0);
        step_a(0, 1, 1, 2'd1, 4'b0001, 2'd0, 1);
        // run to idx=2, div_cnt=2
        repeat (3) step_a(0, 1, 1, 2'd1, 4'b0001, 2'd0, 0);
        repeat (4) step_a(0, 1, 1, 2'd1, 4'b0010, 2'd1, 0);
        repeat (3) step_a(0, 1, 1, 2'd1, 4'b0100, 2'd2, 0);
        // mid-scan reset, then release into DIRECT
        step_a(1, 1, 1, 2'd1, 4'b0000, 2'd0, 0);
        step_a(0, 1, 0, 2'd1, 4'b0010, 2'd1, 0);
        // SCAN -> DIRECT -> SCAN: div_cnt must restart from 0
        step_a(0, 1, 1, 2'd1, 4'b0010, 2'd1, 0);
        step_a(0, 1, 1, 2'd1, 4'b0010, 2'd1, 0);
        step_a(0, 1, 0, 2'd2, 4'b0100, 2'd2, 0);
        step_a(0, 1, 1, 2'd0, 4'b0001, 2'd0, 0);
        repeat (3) step_a(0, 1, 1, 2'd2, 4'b0001, 2'd0, 0);
        step_a(0, 1, 1, 2'd2, 4'b0010, 2'd1, 0);
      end
      begin : stim_b
        step_b(1, 0, 0, 3'd0, 8'h00, 3'd0, 0);
        // DIV=1: SCAN from 0 steps every clock
        step_b(0, 1, 1, 3'd0, 8'h01, 3'd0, 0);
        for (int k = 1; k < 8; k++)
          step_b(0, 1, 1, 3'd5, 8'(1 << k), 3'(k), 0);
        step_b(0, 1, 1, 3'd5, 8'h01, 3'd0, 1);
        step_b(0, 1, 1, 3'd5, 8'h02, 3'd1, 0);
        // DIRECT on the wider instance
        step_b(0, 1, 0, 3'd6, 8'h40, 3'd6, 0);
        step_b(0, 0, 1, 3'd6, 8'h00, 3'd6, 0);
      end
    join

    repeat (2) @(posedge clk);
    #3;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: pending A=%0d B=%0d, expected 0", qa.size(), qb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
